branch_predictor: RTL and testbench

Fetch-stage branch predictor with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters. It gives a taken/target prediction for the current fetch PC in the same cycle. It is trained by the decode-stage branch comparator, whose resolved taken/not-taken result (`up_taken`) and computed target arrive on the update port. It sits between the PC register and the fetch mux, and the pipeline flush logic compares its prediction against the resolved outcome.

---
 rtl/branch_predictor_pkg.sv | 15 +
 rtl/branch_predictor_sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 118 +++++++++++
 tb/tb_branch_predictor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor.
// Counter encodings plus reset and allocation values.
package branch_predictor_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_SN = 2'd0;
  localparam bp_ctr_t BP_WN = 2'd1;
  localparam bp_ctr_t BP_WT = 2'd2;
  localparam bp_ctr_t BP_ST = 2'd3;

  localparam bp_ctr_t BP_CTR_RST   = BP_WN;
  localparam bp_ctr_t BP_CTR_ALLOC = BP_WT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational 2-bit saturating up/down step.
// Holds at strong taken / strong not-taken.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != BP_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != BP_SN) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, 0-cycle lookup.
// Define BP_GSHARE_EN to index counters by pc index xor global history.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pd_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        up_valid,
  input  logic [31:0] up_pc,
  input  logic        up_taken,
  input  logic [31:0] up_target
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [N-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0] tag_q    [N];
  logic [TAG_W-1:0] tag_d    [N];
  logic [31:0]      target_q [N];
  logic [31:0]      target_d [N];
  bp_ctr_t          ctr_q    [N];
  bp_ctr_t          ctr_d    [N];

  logic [IDX_W-1:0] pd_idx, up_idx;
  logic [IDX_W-1:0] pd_cidx, up_cidx;
  logic [TAG_W-1:0] pd_tag, up_tag;
  logic             up_hit;
  bp_ctr_t          up_ctr_cur, up_ctr_nxt;
  logic             unused_pc_lsb;

  assign pd_idx = pd_pc[IDX_W+1:2];
  assign pd_tag = pd_pc[31:IDX_W+2];
  assign up_idx = up_pc[IDX_W+1:2];
  assign up_tag = up_pc[31:IDX_W+2];
  assign unused_pc_lsb = ^{pd_pc[1:0], up_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // Both ports hash with the history seen before this cycle's shift.
  assign pd_cidx = pd_idx ^ ghr_q;
  assign up_cidx = up_idx ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (up_valid) ghr_d = {ghr_q[IDX_W-2:0], up_taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  assign pd_cidx = pd_idx;
  assign up_cidx = up_idx;
`endif

  always_comb begin
    pred_hit    = valid_q[pd_idx] && (tag_q[pd_idx] == pd_tag);
    pred_taken  = pred_hit & ctr_q[pd_cidx][1];
    pred_target = pred_hit ? target_q[pd_idx] : 32'd0;
  end

  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr_cur = ctr_q[up_cidx];

  sat_counter2 u_sat (
    .ctr_i (up_ctr_cur),
    .inc_i (up_taken),
    .ctr_o (up_ctr_nxt)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (up_valid) begin
      unique case (1'b1)
        up_hit: begin
          ctr_d[up_cidx] = up_ctr_nxt;
          if (up_taken) target_d[up_idx] = up_target;
        end
        (!up_hit && up_taken): begin
          valid_d[up_idx]  = 1'b1;
          tag_d[up_idx]    = up_tag;
          target_d[up_idx] = up_target;
          ctr_d[up_cidx]   = BP_CTR_ALLOC;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BP_CTR_RST;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (default build).
// Directed vector table, mid-cycle reset, then random vs. model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pd_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        up_valid = 1'b0;
  logic [31:0] up_pc = '0;
  logic        up_taken = 1'b0;
  logic [31:0] up_target = '0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pd_pc       (pd_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .up_valid    (up_valid),
    .up_pc       (up_pc),
    .up_taken    (up_taken),
    .up_target   (up_target)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 64 entries, plain integers.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void m_look(input logic [31:0] pc,
                                 output logic h, output logic t,
                                 output logic [31:0] tg);
    int i;
    i  = int'((pc >> 2) % 64);
    h  = m_valid[i] && (m_tag[i] == (pc >> 8));
    t  = h && (m_ctr[i] >= 2);
    tg = h ? m_tgt[i] : 32'd0;
  endfunction

  function automatic void m_update(input logic [31:0] pc, input logic t,
                                   input logic [31:0] tg);
    int i;
    bit h;
    i = int'((pc >> 2) % 64);
    h = m_valid[i] && (m_tag[i] == (pc >> 8));
    if (h && t) begin
      m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
      m_tgt[i] = tg;
    end else if (h) begin
      m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
    end else if (t) begin
      m_valid[i] = 1;
      m_tag[i]   = pc >> 8;
      m_tgt[i]   = tg;
      m_ctr[i]   = 2;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pd;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic        e_hit;
    logic        e_tkn;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs [20];

  task automatic set_in(input logic [31:0] pd, input logic uv,
                        input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg);
    pd_pc     = pd;
    up_valid  = uv;
    up_pc     = upc;
    up_taken  = ut;
    up_target = utg;
  endtask

  // Inputs change at posedge+1; outputs sampled at the falling edge.
  task automatic finish_cycle();
    @(posedge clk);
    if (up_valid) m_update(up_pc, up_taken, up_target);
    #1;
  endtask

  initial begin
    logic        mh, mt;
    logic [31:0] mtg;

    vecs[0]  = '{32'h3000, 0, 32'h0,    0, 32'h0,    0, 0, 32'h0};
    vecs[1]  = '{32'h3000, 1, 32'h3000, 1, 32'h3040, 0, 0, 32'h0};
    vecs[2]  = '{32'h3000, 1, 32'h3000, 1, 32'h3040, 1, 1, 32'h3040};
    vecs[3]  = '{32'h3000, 1, 32'h3000, 1, 32'h3040, 1, 1, 32'h3040};
    vecs[4]  = '{32'h3000, 1, 32'h3000, 1, 32'h3040, 1, 1, 32'h3040};
    vecs[5]  = '{32'h3000, 1, 32'h3000, 0, 32'hdead, 1, 1, 32'h3040};
    vecs[6]  = '{32'h3000, 1, 32'h3000, 0, 32'hdead, 1, 1, 32'h3040};
    vecs[7]  = '{32'h3000, 1, 32'h3000, 0, 32'hdead, 1, 0, 32'h3040};
    vecs[8]  = '{32'h3000, 1, 32'h3000, 0, 32'hdead, 1, 0, 32'h3040};
    vecs[9]  = '{32'h3000, 1, 32'h3000, 0, 32'hdead, 1, 0, 32'h3040};
    vecs[10] = '{32'h3000, 1, 32'h3000, 0, 32'hdead, 1, 0, 32'h3040};
    vecs[11] = '{32'h3000, 0, 32'h0,    0, 32'h0,    1, 0, 32'h3040};
    vecs[12] = '{32'h3000, 1, 32'h3000, 1, 32'h3040, 1, 0, 32'h3040};
    vecs[13] = '{32'h3000, 1, 32'h3000, 1, 32'h3040, 1, 0, 32'h3040};
    vecs[14] = '{32'h3000, 0, 32'h0,    0, 32'h0,    1, 1, 32'h3040};
    vecs[15] = '{32'h3000, 1, 32'h3100, 1, 32'h3180, 1, 1, 32'h3040};
    vecs[16] = '{32'h3000, 0, 32'h0,    0, 32'h0,    0, 0, 32'h0};
    vecs[17] = '{32'h3100, 0, 32'h0,    0, 32'h0,    1, 1, 32'h3180};
    vecs[18] = '{32'h5004, 1, 32'h5004, 0, 32'h5100, 0, 0, 32'h0};
    vecs[19] = '{32'h5004, 0, 32'h0,    0, 32'h0,    0, 0, 32'h0};

    m_reset();
    pd_pc = 32'h3000;
    #1;
    chk("rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_target", pred_target, 32'd0);
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 20; v++) begin
      set_in(vecs[v].pd, vecs[v].uv, vecs[v].upc, vecs[v].ut, vecs[v].utg);
      #4;
      chk($sformatf("vec%0d_hit", v), {31'd0, pred_hit},
          {31'd0, vecs[v].e_hit});
      chk($sformatf("vec%0d_taken", v), {31'd0, pred_taken},
          {31'd0, vecs[v].e_tkn});
      chk($sformatf("vec%0d_target", v), pred_target, vecs[v].e_tgt);
      finish_cycle();
    end

    // Asynchronous reset mid-cycle with an update pending.
    set_in(32'h3100, 1, 32'h3100, 1, 32'h9999);
    #4;
    chk("pre_rst_hit", {31'd0, pred_hit}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_hit", {31'd0, pred_hit}, 32'd0);
    chk("arst_taken", {31'd0, pred_taken}, 32'd0);
    chk("arst_target", pred_target, 32'd0);
    @(posedge clk);
    #2;
    up_valid = 1'b0;
    rst_n = 1'b1;
    m_reset();
    #2;
    chk("post_rst_3100", {31'd0, pred_hit}, 32'd0);
    pd_pc = 32'h3000;
    #1;
    chk("post_rst_3000", {31'd0, pred_hit}, 32'd0);
    @(posedge clk);
    #1;
    pd_pc = 32'h3100;
    #1;
    chk("post_rst_edge", {31'd0, pred_hit}, 32'd0);
    @(posedge clk);
    #1;

    // Random traffic over a small pc pool so entries alias and saturate.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rp, ru;
      rp = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      ru = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      set_in(rp, 1'($urandom_range(0, 3) != 0), ru,
             1'($urandom_range(0, 1)), $urandom);
      #4;
      m_look(pd_pc, mh, mt, mtg);
      chk($sformatf("rnd%0d_hit", n), {31'd0, pred_hit}, {31'd0, mh});
      chk($sformatf("rnd%0d_taken", n), {31'd0, pred_taken}, {31'd0, mt});
      chk($sformatf("rnd%0d_target", n), pred_target, mtg);
      finish_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
